// File: rtl/ahbl_sram_ctrl_pkg.sv
// Shared AHB-Lite encodings and byte-lane helpers for the SRAM controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   htrans_e      - AHB HTRANS encodings
//   HSIZE_*       - AHB HSIZE encodings used by the controller
//   fwd_t         - captured forwarding bytes (lane mask + data)
//   be_from_size  - byte-lane mask for a transfer of a given size and offset
package ahbl_sram_ctrl_pkg;

    localparam int W_BUS  = 32;
    localparam int W_LANE = W_BUS / 8;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    // Bytes captured for a read that must be overlaid on the SRAM output.
    typedef struct packed {
        logic [W_LANE-1:0] be;
        logic [W_BUS-1:0]  data;
    } fwd_t;

    // Lane mask of the bytes touched by a transfer. Anything wider than a
    // word is clamped to the full word, since the bus is only 32 bits.
    function automatic logic [W_LANE-1:0] be_from_size(input logic [2:0] hsize,
                                                       input logic [1:0] addr_lo);
        logic [W_LANE-1:0] be;
        case (hsize)
            HSIZE_BYTE: be = 4'b0001 << addr_lo;
            HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/sram_sync.sv
// Single-port synchronous SRAM model with optional per-byte write enables.
// Latency: read data appears one clock after the address is presented.
// Backpressure: none; accepts an access every cycle.
//
// Ports:
//   clk    - clock
//   addr   - word address
//   wen    - per-byte write enable (any bit writes the whole word when BYTE_ENABLE=0)
//   wdata  - write data
//   rdata  - registered read data of the previous cycle's address
module sram_sync #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 2048,
    parameter int BYTE_ENABLE = 1,
    parameter int W_ADDR      = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic [W_ADDR-1:0]    addr,
    input  logic [WIDTH/8-1:0]   wen,
    input  logic [WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]     rdata
);

    localparam int N_LANES = WIDTH / 8;

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage array: no reset, like the macro it stands in for.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_LANES; i++) begin
            if ((BYTE_ENABLE != 0) ? wen[i] : (|wen)) begin
                mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/ahbl_sram_ctrl.sv
// AHB-Lite slave driving a single-port synchronous SRAM with byte enables.
// Latency: zero wait states; read data returned in the data phase after one SRAM cycle.
// Backpressure: never stalls the bus (HREADYOUT tied high); write/read port conflicts absorbed by a one-entry write buffer.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   ahbls_*             - AHB-Lite slave interface (address phase inputs, hwdata/hrdata in data phase)
//   sram_addr/wen/wdata - SRAM request for this cycle (wen=0 means read or idle)
//   sram_rdata          - SRAM data for the address presented on the previous cycle
module ahbl_sram_ctrl
    import ahbl_sram_ctrl_pkg::*;
#(
    parameter int W_DATA      = 32,
    parameter int W_ADDR      = 32,
    parameter int DEPTH       = 2048,
    parameter int W_SRAM_ADDR = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    ahbls_hready,
    output logic                    ahbls_hready_resp,
    output logic                    ahbls_hresp,
    input  logic [W_ADDR-1:0]       ahbls_haddr,
    input  logic                    ahbls_hwrite,
    input  logic [1:0]              ahbls_htrans,
    input  logic [2:0]              ahbls_hsize,
    input  logic [W_DATA-1:0]       ahbls_hwdata,
    output logic [W_DATA-1:0]       ahbls_hrdata,

    output logic [W_SRAM_ADDR-1:0]  sram_addr,
    output logic [W_DATA/8-1:0]     sram_wen,
    output logic [W_DATA-1:0]       sram_wdata,
    input  logic [W_DATA-1:0]       sram_rdata
);

    localparam int W_BE = W_DATA / 8;

    // ------------------------------------------------------------------
    // Address phase decode
    // ------------------------------------------------------------------
    logic                   aph_vld;
    logic                   rd_aph;
    logic                   wr_aph;
    logic [W_SRAM_ADDR-1:0] aph_word;
    logic [W_BE-1:0]        aph_be;

    assign aph_vld  = ahbls_hready &&
                      ((ahbls_htrans == HTRANS_NONSEQ) || (ahbls_htrans == HTRANS_SEQ));
    assign rd_aph   = aph_vld && !ahbls_hwrite;
    assign wr_aph   = aph_vld &&  ahbls_hwrite;
    // Upper address bits are dropped on purpose: the array aliases modulo DEPTH.
    assign aph_word = ahbls_haddr[W_SRAM_ADDR+1:2];
    assign aph_be   = be_from_size(ahbls_hsize, ahbls_haddr[1:0]);

    logic unused_haddr_hi;
    assign unused_haddr_hi = ^ahbls_haddr[W_ADDR-1:W_SRAM_ADDR+2];

    // ------------------------------------------------------------------
    // Data phase and write buffer state
    // ------------------------------------------------------------------
    logic                   wdp_vld;
    logic [W_SRAM_ADDR-1:0] wdp_addr;
    logic [W_BE-1:0]        wdp_be;
    logic                   rdp_vld;

    logic                   wbuf_vld;
    logic [W_SRAM_ADDR-1:0] wbuf_addr;
    logic [W_BE-1:0]        wbuf_be;
    logic [W_DATA-1:0]      wbuf_data;

    fwd_t                   fwd;
    fwd_t                   fwd_nxt;

    logic                   wbuf_load;
    logic                   wbuf_drain;

    // A write data phase that meets a read address phase loses the port;
    // its data only exists this cycle, so it is parked in the buffer.
    assign wbuf_load = wdp_vld && rd_aph;

    // ------------------------------------------------------------------
    // SRAM port arbitration: read address > write data phase > buffer drain
    // ------------------------------------------------------------------
    always_comb begin
        sram_addr  = aph_word;
        sram_wen   = '0;
        sram_wdata = ahbls_hwdata;
        wbuf_drain = 1'b0;
        if (rd_aph) begin
            sram_addr = aph_word;
        end else if (wdp_vld) begin
            sram_addr  = wdp_addr;
            sram_wen   = wdp_be;
            sram_wdata = ahbls_hwdata;
        end else if (wbuf_vld) begin
            sram_addr  = wbuf_addr;
            sram_wen   = wbuf_be;
            sram_wdata = wbuf_data;
            wbuf_drain = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Store-to-load forwarding. The SRAM read issued this cycle cannot see
    // a write still sitting in the data phase or in the buffer, so those
    // bytes are captured now and overlaid when sram_rdata returns. The
    // data phase write is the younger of the two and wins.
    // ------------------------------------------------------------------
    always_comb begin
        fwd_nxt.be   = '0;
        fwd_nxt.data = ahbls_hwdata;
        if (wdp_vld && (wdp_addr == aph_word)) begin
            fwd_nxt.be   = wdp_be;
            fwd_nxt.data = ahbls_hwdata;
        end else if (wbuf_vld && (wbuf_addr == aph_word)) begin
            fwd_nxt.be   = wbuf_be;
            fwd_nxt.data = wbuf_data;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdp_vld   <= 1'b0;
            wdp_addr  <= '0;
            wdp_be    <= '0;
            rdp_vld   <= 1'b0;
            wbuf_vld  <= 1'b0;
            wbuf_addr <= '0;
            wbuf_be   <= '0;
            wbuf_data <= '0;
            fwd       <= '0;
        end else begin
            wdp_vld <= wr_aph;
            rdp_vld <= rd_aph;
            if (wr_aph) begin
                wdp_addr <= aph_word;
                wdp_be   <= aph_be;
            end
            // Load and drain are mutually exclusive (load needs a read
            // address phase, which blocks the drain), and a write address
            // phase always leaves the port free to drain, so a loaded
            // buffer is empty again before the next write data phase.
            if (wbuf_load) begin
                wbuf_vld  <= 1'b1;
                wbuf_addr <= wdp_addr;
                wbuf_be   <= wdp_be;
                wbuf_data <= ahbls_hwdata;
            end else if (wbuf_drain) begin
                wbuf_vld  <= 1'b0;
            end
            if (rd_aph) begin
                fwd <= fwd_nxt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read data: byte-wise merge of forwarded bytes over SRAM output.
    // Held at zero outside a read data phase so an uninitialised SRAM
    // never leaks X onto the bus.
    // ------------------------------------------------------------------
    logic [W_DATA-1:0] rdata_merged;

    always_comb begin
        rdata_merged = sram_rdata;
        for (int i = 0; i < W_BE; i++) begin
            if (fwd.be[i]) begin
                rdata_merged[i*8 +: 8] = fwd.data[i*8 +: 8];
            end
        end
    end

    assign ahbls_hrdata      = rdp_vld ? rdata_merged : '0;
    assign ahbls_hready_resp = 1'b1;
    assign ahbls_hresp       = 1'b0;

endmodule
